// File: rtl/isa_test_monitor.sv
// End-of-test monitor for ISA compliance runs: watches the fetch PC stream for the
// pass/fail trap signatures, enforces a cycle budget and latches a sticky verdict.
module isa_test_monitor #(
    parameter int unsigned             XLEN       = 32,
    parameter logic [XLEN-1:0]         PASS_PC    = 32'h0000_05f0,
    parameter logic [XLEN-1:0]         FAIL_PC    = 32'h0000_05dc,
    parameter int unsigned             SIG_OFFSET = 8,
    parameter int unsigned             HOLD_CNT   = 2,
    parameter int unsigned             HCNT_W     = 8,
    parameter int unsigned             CYC_W      = 32,
    parameter int unsigned             TIMEOUT    = 650
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              pc_valid_i,
    output logic [2:0]        state_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              timeout_o,
    output logic [CYC_W-1:0]  cycle_o,
    output logic [XLEN-1:0]   verdict_pc_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam logic [XLEN-1:0]   PASS_SIG = XLEN'(PASS_PC + XLEN'(SIG_OFFSET));
    localparam logic [XLEN-1:0]   FAIL_SIG = XLEN'(FAIL_PC + XLEN'(SIG_OFFSET));
    localparam logic [HCNT_W-1:0] HOLD_V   = HCNT_W'(HOLD_CNT);
    localparam logic              TO_EN    = (TIMEOUT != 0);
    localparam logic [CYC_W-1:0]  TO_LAST  = (TIMEOUT == 0) ? {CYC_W{1'b0}} : CYC_W'(TIMEOUT - 1);

    state_t            state_r;
    logic [HCNT_W-1:0] pass_cnt_r;
    logic [HCNT_W-1:0] fail_cnt_r;
    logic [CYC_W-1:0]  cyc_r;
    logic              done_r;
    logic              pass_r;
    logic              fail_r;
    logic              timeout_r;
    logic [CYC_W-1:0]  cycle_r;
    logic [XLEN-1:0]   verdict_pc_r;

    logic              hit_p_s;
    logic              hit_f_s;
    logic              hit_t_s;

    function automatic logic [HCNT_W-1:0] sat_inc_h(input logic [HCNT_W-1:0] v);
        return (&v) ? v : v + HCNT_W'(1);
    endfunction

    function automatic logic [CYC_W-1:0] sat_inc_c(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

    // Verdict qualification uses the pre-edge hold counts, so an overshoot never fires.
    always_comb begin
        hit_p_s = 1'b0;
        hit_f_s = 1'b0;
        hit_t_s = 1'b0;
        if ((state_r == ST_RUN) && pc_valid_i) begin
            hit_p_s = (pass_cnt_r == HOLD_V) && (pc_i == PASS_SIG);
            hit_f_s = (fail_cnt_r == HOLD_V) && (pc_i == FAIL_SIG);
        end else begin
            hit_p_s = 1'b0;
            hit_f_s = 1'b0;
        end
        if (state_r == ST_RUN) begin
            hit_t_s = TO_EN && (cyc_r == TO_LAST);
        end else begin
            hit_t_s = 1'b0;
        end
    end

    // Run-control FSM with counters and registered verdict outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pass_cnt_r   <= {HCNT_W{1'b0}};
            fail_cnt_r   <= {HCNT_W{1'b0}};
            cyc_r        <= {CYC_W{1'b0}};
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_r       <= 1'b0;
            timeout_r    <= 1'b0;
            cycle_r      <= {CYC_W{1'b0}};
            verdict_pc_r <= {XLEN{1'b0}};
        end else if (clear_i) begin
            state_r      <= ST_IDLE;
            pass_cnt_r   <= {HCNT_W{1'b0}};
            fail_cnt_r   <= {HCNT_W{1'b0}};
            cyc_r        <= {CYC_W{1'b0}};
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_r       <= 1'b0;
            timeout_r    <= 1'b0;
            cycle_r      <= {CYC_W{1'b0}};
            verdict_pc_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pass_cnt_r <= {HCNT_W{1'b0}};
                    fail_cnt_r <= {HCNT_W{1'b0}};
                    cyc_r      <= {CYC_W{1'b0}};
                    if (start_i) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    cyc_r   <= sat_inc_c(cyc_r);
                    cycle_r <= cyc_r;
                    if (pc_valid_i) begin
                        pass_cnt_r <= (pc_i >= PASS_PC) ? sat_inc_h(pass_cnt_r) : {HCNT_W{1'b0}};
                        fail_cnt_r <= (pc_i >= FAIL_PC) ? sat_inc_h(fail_cnt_r) : {HCNT_W{1'b0}};
                    end else begin
                        pass_cnt_r <= pass_cnt_r;
                        fail_cnt_r <= fail_cnt_r;
                    end
                    if (hit_p_s) begin
                        state_r      <= ST_PASS;
                        done_r       <= 1'b1;
                        pass_r       <= 1'b1;
                        verdict_pc_r <= pc_i;
                    end else if (hit_f_s) begin
                        state_r      <= ST_FAIL;
                        done_r       <= 1'b1;
                        fail_r       <= 1'b1;
                        verdict_pc_r <= pc_i;
                    end else if (hit_t_s) begin
                        state_r      <= ST_TIMEOUT;
                        done_r       <= 1'b1;
                        timeout_r    <= 1'b1;
                        verdict_pc_r <= pc_valid_i ? pc_i : {XLEN{1'b0}};
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o      = state_r;
    assign done_o       = done_r;
    assign pass_o       = pass_r;
    assign fail_o       = fail_r;
    assign timeout_o    = timeout_r;
    assign cycle_o      = cycle_r;
    assign verdict_pc_o = verdict_pc_r;

endmodule

// File: tb/tb_isa_test_monitor.sv
// Scoreboard bench for isa_test_monitor: directed PC streams push expected output
// snapshots; a monitor process pops and compares them on the falling clock edge.
module tb_isa_test_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [31:0] pc_i = 32'h0;
    logic        pc_valid_i = 1'b0;
    logic [2:0]  state_o;
    logic        done_o, pass_o, fail_o, timeout_o;
    logic [31:0] cycle_o;
    logic [31:0] verdict_pc_o;

    localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_PASS = 3'd2, S_FAIL = 3'd3, S_TO = 3'd4;

    isa_test_monitor #(.TIMEOUT(10)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
        .pc_i(pc_i), .pc_valid_i(pc_valid_i), .state_o(state_o), .done_o(done_o),
        .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
        .cycle_o(cycle_o), .verdict_pc_o(verdict_pc_o)
    );

    always #5 clk = ~clk;

    int ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    typedef struct {
        string       name;
        int          due;
        logic [2:0]  st;
        logic [31:0] pc;
        logic [31:0] cy;
        bit          chk_cy;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic expect_out(input string n, input logic [2:0] st, input logic [31:0] pc,
                              input logic [31:0] cy, input bit ccy);
        exp_t e;
        e.name = n; e.due = ncyc; e.st = st; e.pc = pc; e.cy = cy; e.chk_cy = ccy;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit v, input logic [31:0] pc);
        pc_valid_i = v;
        pc_i = pc;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1; pc_valid_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1; pc_valid_i = 1'b0;
        @(posedge clk); #1;
        clear_i = 1'b0;
    endtask

    // Monitor: compare every snapshot that has come due against the DUT outputs.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= ncyc) begin
                exp_t e;
                bit ok;
                e = exp_q.pop_front();
                ok = (state_o == e.st) && (done_o == (e.st >= S_PASS)) &&
                     (pass_o == (e.st == S_PASS)) && (fail_o == (e.st == S_FAIL)) &&
                     (timeout_o == (e.st == S_TO)) && (verdict_pc_o == e.pc) &&
                     (!e.chk_cy || cycle_o == e.cy);
                tests++;
                if (!ok) begin
                    fails++;
                    $display("FAIL %s: got state=%0d done=%b pass=%b fail=%b timeout=%b pc=%h cycle=%0d; want state=%0d pc=%h cycle=%0d%s",
                             e.name, state_o, done_o, pass_o, fail_o, timeout_o, verdict_pc_o, cycle_o,
                             e.st, e.pc, e.cy, e.chk_cy ? "" : "(any)");
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", S_IDLE, 32'h0, 32'd0, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Pass path
        pulse_start();
        expect_out("run_entry", S_RUN, 32'h0, 32'd0, 1'b1);
        step(1'b1, 32'h100);
        step(1'b1, 32'h5f0);
        step(1'b1, 32'h5f4);
        step(1'b1, 32'h5f8);
        expect_out("pass", S_PASS, 32'h5f8, 32'd3, 1'b1);
        pulse_clear();
        expect_out("clear_after_pass", S_IDLE, 32'h0, 32'd0, 1'b1);

        // Fail path and stickiness
        pulse_start();
        step(1'b1, 32'h5dc);
        step(1'b1, 32'h5e0);
        step(1'b1, 32'h5e4);
        expect_out("fail", S_FAIL, 32'h5e4, 32'd2, 1'b1);
        step(1'b1, 32'h5f8);
        expect_out("fail_sticky_pc", S_FAIL, 32'h5e4, 32'd2, 1'b1);
        pulse_start();
        expect_out("fail_sticky_start", S_FAIL, 32'h5e4, 32'd2, 1'b1);
        pulse_clear();

        // Hold counter reset by a low PC
        pulse_start();
        step(1'b1, 32'h5f0);
        step(1'b1, 32'h100);
        step(1'b1, 32'h5f4);
        step(1'b1, 32'h5f8);
        expect_out("hold_no_pass", S_RUN, 32'h0, 32'd0, 1'b0);
        step(1'b1, 32'h5fc);
        expect_out("hold_overshoot", S_RUN, 32'h0, 32'd0, 1'b0);
        pulse_clear();

        // Bubbles carry the signature PC but must neither fire nor move the counters
        pulse_start();
        step(1'b1, 32'h5f0);
        step(1'b0, 32'h5f8);
        expect_out("bubble_no_fire", S_RUN, 32'h0, 32'd0, 1'b0);
        step(1'b1, 32'h5f4);
        step(1'b0, 32'h5f8);
        step(1'b1, 32'h5f8);
        expect_out("bubble_pass", S_PASS, 32'h5f8, 32'd4, 1'b1);
        pulse_clear();

        // Watchdog, clear and restart
        pulse_start();
        for (int i = 0; i < 9; i++) step(1'b1, 32'h40);
        expect_out("pre_timeout", S_RUN, 32'h0, 32'd0, 1'b0);
        step(1'b1, 32'h40);
        expect_out("timeout", S_TO, 32'h40, 32'd9, 1'b1);
        pulse_clear();
        expect_out("clear_after_timeout", S_IDLE, 32'h0, 32'd0, 1'b1);
        pulse_start();
        for (int i = 0; i < 9; i++) step(1'b1, 32'h40);
        step(1'b0, 32'h40);
        expect_out("timeout_restart", S_TO, 32'h0, 32'd9, 1'b1);
        pulse_clear();

        // Asynchronous reset between edges mid-run
        pulse_start();
        step(1'b1, 32'h5f0);
        step(1'b1, 32'h5f4);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", S_IDLE, 32'h0, 32'd0, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // clear_i beats a qualifying pass PC on the same edge
        pulse_start();
        step(1'b1, 32'h5f0);
        step(1'b1, 32'h5f4);
        clear_i = 1'b1;
        step(1'b1, 32'h5f8);
        clear_i = 1'b0;
        expect_out("clear_wins", S_IDLE, 32'h0, 32'd0, 1'b1);
        step(1'b0, 32'h0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d snapshots left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/isa_test_monitor.md
Name: isa_test_monitor

Overview:
Synthesizable end-of-test monitor for ISA compliance runs on the NF5 core. It watches the fetch-stage PC stream and detects the pass and fail trap signatures. It also enforces a cycle-budget watchdog and latches a sticky verdict with the cycle stamp and PC. It generalises the bench-only pass/fail PC check with run control, timeout, clear/restart and parametrised signature geometry.

Parameters:
XLEN, 32, PC width
PASS_PC, 32'h000005f0, base address of the pass trap loop
FAIL_PC, 32'h000005dc, base address of the fail trap loop
SIG_OFFSET, 8, byte offset from the base at which the verdict fires
HOLD_CNT, 2, consecutive qualifying PCs required before the verdict fires
HCNT_W, 8, width of the hold counters; saturating
CYC_W, 32, width of the cycle counter
TIMEOUT, 650, cycle budget; 0 disables the watchdog

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  pulse; IDLE->RUN
clear_i  in  1  pulse; any state->IDLE, clears all status
pc_i  in  XLEN  IF/ID current PC
pc_valid_i  in  1  pc_i is meaningful this cycle
state_o  out  3  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT
done_o  out  1  high in PASS, FAIL or TIMEOUT
pass_o  out  1  high in PASS
fail_o  out  1  high in FAIL
timeout_o  out  1  high in TIMEOUT
cycle_o  out  CYC_W  cycles spent in RUN; frozen once a verdict is reached
verdict_pc_o  out  XLEN  pc_i sampled on the verdict edge

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, all outputs 0, both hold counters 0, cycle counter 0.
- IDLE: counters held at 0. start_i=1 -> RUN on the next edge. clear_i has priority over start_i in every state.
- RUN, each edge:
  - cyc <= cyc+1. The counter saturates at all-ones.
  - When pc_valid_i=1: pass_cnt <= (pc_i >= PASS_PC) ? sat(pass_cnt+1) : 0. fail_cnt uses the same rule against FAIL_PC. Comparisons are unsigned XLEN.
  - When pc_valid_i=0: hold counters keep their values.
- Verdict conditions, evaluated in RUN against pre-edge (registered) counter values and the current pc_i, only when pc_valid_i=1:
  - P: pass_cnt == HOLD_CNT and pc_i == PASS_PC+SIG_OFFSET.
  - F: fail_cnt == HOLD_CNT and pc_i == FAIL_PC+SIG_OFFSET.
  - T: TIMEOUT != 0 and cyc == TIMEOUT-1.
- Priority: P > F > T. On the verdict edge:
  - state moves to PASS, FAIL or TIMEOUT.
  - verdict_pc_o <= pc_i. On TIMEOUT with pc_valid_i=0, the value is 0.
  - cycle_o <= cyc; cycle_o does not include the verdict cycle.
  - cycle_o tracks cyc every RUN cycle before the verdict.
- PASS, FAIL and TIMEOUT are sticky. They leave only via clear_i (-> IDLE, all status 0) or reset. start_i is ignored in these states.
- Equality is exact. The counter must equal HOLD_CNT at the moment the target PC appears, so an overshoot never fires.
- Latency: verdict outputs assert on the edge after the qualifying pc_i is presented (1 cycle).
- The block has no combinational path from inputs to outputs.
- clear_i and the verdict on the same edge: clear_i wins and state becomes IDLE.
- Reset mid-RUN aborts immediately with no verdict.

Test Plan:
- Pass path: reset, start_i; pc 0x100,0x5f0,0x5f4,0x5f8 valid on consecutive cycles -> pass_o=1, state_o=2, verdict_pc_o=0x5f8, cycle_o=3 on the edge after 0x5f8; fail_o=0.
- Fail path: pc 0x5dc,0x5e0,0x5e4 -> fail_o=1, verdict_pc_o=0x5e4. Then pc 0x5f8 -> state stays FAIL (sticky).
- Hold reset: pc 0x5f0,0x100,0x5f4,0x5f8 -> no verdict at 0x5f8 (pass_cnt=1). Follow-up 0x5fc -> still no pass.
- Bubbles: pc 0x5f0,(valid=0),0x5f4,(valid=0),0x5f8 -> pass fires on 0x5f8; hold counters held through the bubbles.
- Timeout: TIMEOUT=10, pc held at 0x40 -> timeout_o=1 after exactly 10 RUN cycles, cycle_o=9. Then clear_i -> state 0, all outputs 0. start_i again -> RUN, cyc restarts at 0.
- Async reset asserted mid-RUN, between edges -> all outputs 0 immediately. clear_i and a P-qualifying pc on the same edge -> IDLE, pass_o=0.
